// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Queue entries pair a fetched instruction with the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_ADDR_W     = 24;
    localparam int FETCH_INSTR_W    = 24;
    localparam int FETCH_MIN_QDEPTH = 2;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with wrapping read/write pointers.
// flush_i clears the queue and takes priority over push_i.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-cycle-latency imem requests and a decoupling queue.
// Optional FETCH_BYPASS_EN lets a response reach out_* in its arrival cycle when the queue is empty.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter int                PC_STEP  = 4,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_next
);

    localparam int QD    = (QDEPTH < FETCH_MIN_QDEPTH) ? FETCH_MIN_QDEPTH : QDEPTH;
    localparam int CNT_W = $clog2(QD + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              inflight_q, inflight_d;
    logic              squash_q, squash_d;

    logic             q_push, q_pop, q_flush, q_full, q_empty;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     q_head, resp_entry, out_entry;
    logic             resp_valid, bypass;

    // Issue only with a free slot for every queued and in-flight entry; a same-cycle pop earns no credit.
    assign occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
    assign imem_req  = !rst && !redirect_valid && (occupancy < (CNT_W + 1)'(QD));
    assign imem_addr = pc_q;

    always_comb begin
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = imem_req;
        squash_d   = redirect_valid;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (imem_req) begin
            pc_d      = pc_q + ADDR_W'(PC_STEP);
            pend_pc_d = pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    assign resp_valid = inflight_q && !squash_q;
    assign resp_entry = '{pc: pend_pc_q, instr: imem_rdata};

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_valid && q_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response that decode takes immediately never occupies a queue slot.
    assign q_push  = resp_valid && !(bypass && out_ready);
    assign q_pop   = !q_empty && out_ready;
    assign q_flush = redirect_valid;

    fetch_queue #(
        .DEPTH (QD),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk     (CLK),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .wdata_i (resp_entry),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign out_entry   = bypass ? resp_entry : q_head;
    assign out_valid   = !q_empty || bypass;
    assign out_instr   = out_entry.instr;
    assign out_pc      = out_entry.pc;
    assign out_pc_next = out_entry.pc + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed phases drive stimulus and queue expected
// {pc, instr, pc_next} triples; a negedge monitor checks every accepted head in order.
module tb_fetch_unit;

    localparam int AW  = 24;
    localparam int IW  = 24;
    localparam int EW  = AW + IW + AW;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          CLK;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_pc_next;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;
    int n_pops;
    int nreq;

    fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .PC_STEP  (4),
        .QDEPTH   (4),
        .RESET_PC (24'h000000)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_next    (out_pc_next)
    );

    // Clock / reset block
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] pc);
        return {pc[11:0], pc[23:12]} ^ 24'hC3A55A;
    endfunction

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge CLK) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reload(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = base + AW'(4 * i);
            exp_q.push_back({pc, instr_of(pc), pc + AW'(4)});
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        logic [EW-1:0] e;
        if (!rst && out_valid && out_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pop", {8'd0, out_pc}, 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc",      {8'd0, out_pc},      {8'd0, e[EW-1 -: AW]});
                chk("sb_instr",   {8'd0, out_instr},   {8'd0, e[AW+IW-1 -: IW]});
                chk("sb_pc_next", {8'd0, out_pc_next}, {8'd0, e[AW-1:0]});
            end
        end
        if (!rst && !redirect_valid && dut.q_push && dut.q_full && !dut.q_pop) begin
            errors++;
            $display("FAIL overflow: push into full queue at %0t", $time);
        end
    end

    // Driver
    initial begin
        checks = 0; errors = 0; n_pops = 0; nreq = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        at_neg();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imem_req",  {31'd0, imem_req},  32'd0);

        // Sequential stream from RESET_PC with decode always ready
        reload(24'h000000, 40);
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            at_neg();
            chk("a_req",   {31'd0, imem_req},  32'd1);
            chk("a_addr",  {8'd0, imem_addr},  32'(4 * c));
            chk("a_valid", {31'd0, out_valid}, (c >= LAT) ? 32'd1 : 32'd0);
            if (c == LAT) chk("a_first_pc", {8'd0, out_pc}, 32'd0);
            next_cycle();
        end

        // Redirect with decode stalled: queue fills with exactly QDEPTH fetches
        redirect_valid = 1'b1; redirect_pc = 24'h000200; out_ready = 1'b0;
        reload(24'h000200, 40);
        at_neg();
        chk("b_redir_req", {31'd0, imem_req}, 32'd0);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            redirect_valid = 1'b0;
            at_neg();
            if (imem_req) nreq++;
        end
        chk("b_nreq",      32'(nreq),              32'd4);
        chk("b_req_low",   {31'd0, imem_req},      32'd0);
        chk("b_count",     32'(dut.q_count),       32'd4);

        // Release decode: pops resume without a gap
        next_cycle();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            chk("c_no_gap", {31'd0, out_valid}, 32'd1);
            next_cycle();
        end
        out_ready = 1'b0;
        next_cycle();
        redirect_valid = 1'b1; redirect_pc = 24'h000100;
        reload(24'h000100, 40);
        at_neg();
        chk("c_pre_count",    32'(dut.q_count),        32'd3);
        chk("c_pre_inflight", {31'd0, dut.inflight_q}, 32'd1);
        chk("c_redir_req",    {31'd0, imem_req},       32'd0);
        next_cycle();
        redirect_valid = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("c_r1_valid", {31'd0, out_valid}, 32'd0);
        chk("c_r1_req",   {31'd0, imem_req},  32'd1);
        chk("c_r1_addr",  {8'd0, imem_addr},  32'h000100);
        for (int k = 2; k <= 3; k++) begin
            next_cycle();
            at_neg();
            chk("c_r_valid", {31'd0, out_valid}, (k >= LAT + 1) ? 32'd1 : 32'd0);
            if (k == LAT + 1) chk("c_r_first_pc", {8'd0, out_pc}, 32'h000100);
        end
        repeat (4) next_cycle();

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 24'hFFFFF8; out_ready = 1'b0;
        reload(24'hFFFFF8, 40);
        next_cycle();
        redirect_valid = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("d_addr0", {8'd0, imem_addr}, 32'h00FFFFF8);
        next_cycle();
        at_neg();
        chk("d_addr1", {8'd0, imem_addr}, 32'h00FFFFFC);
        next_cycle();
        at_neg();
        chk("d_wrap",  {8'd0, imem_addr}, 32'h00000000);
        repeat (6) next_cycle();

        // One-cycle reset mid-stream with a fetch in flight
        rst = 1'b1; out_ready = 1'b0;
        reload(24'h000000, 40);
        at_neg();
        chk("e_rst_req",      {31'd0, imem_req},       32'd0);
        chk("e_rst_inflight", {31'd0, dut.inflight_q}, 32'd1);
        next_cycle();
        rst = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("e_req",   {31'd0, imem_req},  32'd1);
        chk("e_addr",  {8'd0, imem_addr},  32'd0);
        chk("e_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 2; k <= 3; k++) begin
            next_cycle();
            at_neg();
            chk("e_r_valid", {31'd0, out_valid}, (k >= LAT + 1) ? 32'd1 : 32'd0);
            if (k == LAT + 1) chk("e_first_pc", {8'd0, out_pc}, 32'd0);
        end
        for (int c = 0; c < 4; c++) begin
            next_cycle();
`ifdef FETCH_BYPASS_EN
            at_neg();
            chk("f_bypass_count", 32'(dut.q_count), 32'd0);
`endif
        end

        next_cycle();
        out_ready = 1'b0;
        chk("sb_activity", (n_pops >= 20) ? 32'd1 : 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with a decoupling instruction queue, sitting between the PC/instruction memory and the decode stage. Holds the PC, issues one request per cycle to a synchronous instruction memory (fixed one-cycle read latency), and buffers returned instructions with their PC in a small FIFO. Decode consumes them through a valid/ready handshake. A redirect input (branch/jump) retargets the PC and discards all queued and in-flight fetches.

## Interface
- ADDR_W, 24: PC / memory address width.
- INSTR_W, 24: instruction width.
- PC_STEP, 4: PC increment per sequential fetch.
- QDEPTH, 4: instruction queue entries; minimum 2, full throughput needs ≥3.
- RESET_PC, 0: PC value after reset.

- CLK  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address (equals current PC).
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after an accepted imem_req.
- redirect_valid  in  1  redirect PC this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  head PC.
- out_pc_next  out  ADDR_W  out_pc + PC_STEP, modulo 2^ADDR_W.

## Operation
- Issue: imem_req = !rst && !redirect_valid && (count + inflight < QDEPTH), using registered count/inflight. No credit for a same-cycle pop.
- On issue: PC <= PC + PC_STEP, wrapping modulo 2^ADDR_W. The issuing PC is captured in a pending-PC register. inflight <= 1; otherwise inflight <= 0.
- Response: in the cycle after an issue, {pending PC, imem_rdata} is pushed into the queue, unless it was squashed.
- Handshake: a pop happens when out_valid && out_ready. Push and pop may occur in the same cycle, including when the queue is full (count unchanged). out_* hold stable while out_valid && !out_ready.
- Redirect: PC <= redirect_pc. The queue is cleared (count <= 0). The in-flight response is marked squashed and is not pushed next cycle.
  - A head accepted in the same cycle as a redirect counts as consumed.
  - Fetch at redirect_pc issues in the following cycle.
- Back-to-back redirects: the last one wins. Each squashes everything before it.
- The queue is a circular buffer with wrapping read/write pointers. count width is $clog2(QDEPTH+1).
- Overflow is impossible by construction; the bench asserts it.

## Timing
- Reset values: PC=RESET_PC, count=0, inflight=0, squash=0, pointers=0, out_valid=0, imem_req=0. out_instr/out_pc are don't-care while out_valid=0.
- Reset is taken on any cycle, including mid-fetch. An in-flight response arriving after reset is dropped.
- The first imem_req occurs in the first cycle with rst=0, at addr=RESET_PC.
- Latency, request to out_valid: 2 cycles (request t, data t+1, out_valid t+2). With the bypass feature enabled it is 1 cycle (see Configuration).
- Throughput: 1 instruction/cycle sustained when QDEPTH≥3 and out_ready is held high.
- Redirect at cycle r: imem_req=0 in cycle r, out_valid=0 in r+1, request to redirect_pc in r+1, first redirected instruction visible in r+3 (r+2 with bypass).

## Configuration
- FETCH_BYPASS_EN defined: when the queue is empty and an unsquashed response arrives, the response drives out_* combinationally in the same cycle, with out_valid=1.
  - If out_ready=1, it is consumed and never written to the queue.
  - If out_ready=0, it is written to the queue as normal.
- FETCH_BYPASS_EN undefined: responses are always written to the queue and out_* come only from the queue head (registered path, 2-cycle latency).

## Structure
- Package fetch_pkg:
  - typedef fetch_entry_t {pc, instr}, sized from package-level ADDR_W/INSTR_W defaults.
  - localparam for the minimum QDEPTH.
- Sub-module fetch_queue: parametrised circular FIFO of fetch_entry_t.
  - Ports: push, pop, flush, head, count, full, empty.
  - flush has priority over push.
- fetch_unit holds the PC, inflight/squash bookkeeping, the issue logic and the bypass mux.

## Test plan
- Reset then out_ready=1 for 8 cycles (no bypass) -> imem_addr 0,4,8,…; out_valid first high in cycle 2 with out_pc=0, then 4, 8, … every cycle; out_pc_next=out_pc+4.
- out_ready=0 for 10 cycles -> exactly QDEPTH=4 requests issued, then imem_req=0; count=4. Then out_ready=1 -> pops resume with no gap and no duplicate or lost PC.
- redirect_valid=1, redirect_pc=0x000100 while the queue holds 3 entries and one fetch is in flight -> out_valid=0 next cycle; the squashed data never appears; next out_pc=0x000100.
- PC=0xFFFFFC, sequential fetch -> next imem_addr=0x000000; out_pc_next of that entry = 0x000000.
- Assert rst for one cycle mid-stream with one fetch in flight -> next cycle imem_addr=RESET_PC, out_valid=0, and the stale response is not queued.
- FETCH_BYPASS_EN defined, queue empty, out_ready=1 -> out_valid high 1 cycle after the request, and count stays 0.
